// File: rtl/sync_fifo_ctl_if.sv
// Handshake and status bundle for sync_fifo_ctl.
// The producer/consumer side uses master; the FIFO itself uses slave.
interface sync_fifo_ctl_if #(
    parameter int DSIZE = 32,
    parameter int ASIZE = 4
);
    logic [DSIZE-1:0] wdata;
    logic             winc;
    logic             rinc;
    logic             flush;
    logic             clr_err;
    logic [DSIZE-1:0] rdata;
    logic             wfull;
    logic             rempty;
    logic             walmost_full;
    logic             ralmost_empty;
    logic [ASIZE:0]   count;
    logic             overflow;
    logic             underflow;

    modport master (
        output wdata, winc, rinc, flush, clr_err,
        input  rdata, wfull, rempty, walmost_full, ralmost_empty, count, overflow, underflow
    );

    modport slave (
        input  wdata, winc, rinc, flush, clr_err,
        output rdata, wfull, rempty, walmost_full, ralmost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_ctl.sv
// Single-clock FIFO with registered or first-word-fall-through read, programmable
// almost-full/almost-empty thresholds, synchronous flush and sticky error flags.
module sync_fifo_ctl #(
    parameter int DSIZE      = 32,
    parameter int ASIZE      = 4,
    parameter bit FWFT       = 1'b0,
    parameter int AFULL_LVL  = (1 << ASIZE) - 2,
    parameter int AEMPTY_LVL = 2
) (
    input logic           clk,
    input logic           rst_n,
    sync_fifo_ctl_if.slave bus
);
    localparam int DEPTH = 1 << ASIZE;
    localparam logic [ASIZE:0] FULL_CNT   = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0] AFULL_CNT  = (ASIZE+1)'(AFULL_LVL);
    localparam logic [ASIZE:0] AEMPTY_CNT = (ASIZE+1)'(AEMPTY_LVL);

    logic [DSIZE-1:0] mem [DEPTH];
    logic [ASIZE-1:0] wptr;
    logic [ASIZE-1:0] rptr;
    logic [ASIZE:0]   count_q;
    logic [ASIZE:0]   count_n;
    logic             wfull_q;
    logic             rempty_q;
    logic             afull_q;
    logic             aempty_q;
    logic             ovf_q;
    logic             udf_q;
    logic             racc;
    logic             wacc;

    // A write at full is only taken when a pop frees the slot in the same cycle.
    always_comb begin
        racc    = ~bus.flush & bus.rinc & ~rempty_q;
        wacc    = ~bus.flush & bus.winc & (~wfull_q | racc);
        count_n = count_q + {{ASIZE{1'b0}}, wacc} - {{ASIZE{1'b0}}, racc};
        if (bus.flush) begin
            count_n = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            count_q  <= '0;
            wfull_q  <= 1'b0;
            rempty_q <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            if (bus.flush) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (wacc) wptr <= wptr + 1'b1;
                if (racc) rptr <= rptr + 1'b1;
            end
            count_q  <= count_n;
            wfull_q  <= (count_n == FULL_CNT);
            rempty_q <= (count_n == '0);
            afull_q  <= (count_n >= AFULL_CNT);
            aempty_q <= (count_n <= AEMPTY_CNT);

            // Setting beats clearing; a flush cycle never raises an error.
            if (!bus.flush && bus.winc && !wacc) begin
                ovf_q <= 1'b1;
            end else if (bus.clr_err) begin
                ovf_q <= 1'b0;
            end
            if (!bus.flush && bus.rinc && rempty_q) begin
                udf_q <= 1'b1;
            end else if (bus.clr_err) begin
                udf_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wacc) begin
            mem[wptr] <= bus.wdata;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            assign bus.rdata = mem[rptr];
        end else begin : g_reg
            logic [DSIZE-1:0] rdata_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_q <= '0;
                end else if (racc) begin
                    rdata_q <= mem[rptr];
                end
            end

            assign bus.rdata = rdata_q;
        end
    endgenerate

    assign bus.count         = count_q;
    assign bus.wfull         = wfull_q;
    assign bus.rempty        = rempty_q;
    assign bus.walmost_full  = afull_q;
    assign bus.ralmost_empty = aempty_q;
    assign bus.overflow      = ovf_q;
    assign bus.underflow     = udf_q;
endmodule

// File: tb/tb_sync_fifo_ctl.sv
// Drives a registered-read and a FWFT instance with identical stimulus and checks
// both against a queue-based model of the FIFO rules.
module tb_sync_fifo_ctl;
    localparam int DEPTH = 16;
    localparam logic [10:0] RST_ST = {5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;

    logic [31:0] mq[$];
    logic        m_ovf;
    logic        m_udf;
    logic [31:0] m_rdata;

    sync_fifo_ctl_if #(.DSIZE(32), .ASIZE(4)) if0 ();
    sync_fifo_ctl_if #(.DSIZE(32), .ASIZE(4)) if1 ();

    sync_fifo_ctl #(.DSIZE(32), .ASIZE(4), .FWFT(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    sync_fifo_ctl #(.DSIZE(32), .ASIZE(4), .FWFT(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    logic [10:0] st0;
    logic [10:0] st1;
    assign st0 = {if0.count, if0.wfull, if0.rempty, if0.walmost_full, if0.ralmost_empty, if0.overflow, if0.underflow};
    assign st1 = {if1.count, if1.wfull, if1.rempty, if1.walmost_full, if1.ralmost_empty, if1.overflow, if1.underflow};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] exp_st();
        int n;
        n = mq.size();
        return {5'(n), n == DEPTH, n == 0, n >= DEPTH - 2, n <= 2, m_ovf, m_udf};
    endfunction

    function automatic logic [31:0] head();
        return (mq.size() > 0) ? mq[0] : 32'h0;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        m_rdata = 32'h0;
    endtask

    task automatic set_inputs(input logic w, input logic r, input logic f, input logic c, input logic [31:0] d);
        if0.winc = w; if0.rinc = r; if0.flush = f; if0.clr_err = c; if0.wdata = d;
        if1.winc = w; if1.rinc = r; if1.flush = f; if1.clr_err = c; if1.wdata = d;
    endtask

    // One clock of stimulus; the model advances by the FIFO's queue semantics.
    task automatic drive_cycle(input logic w, input logic r, input logic f, input logic c, input logic [31:0] d);
        int   n;
        logic rd_ok;
        logic wr_ok;
        set_inputs(w, r, f, c, d);
        @(posedge clk);
        #1;
        n = mq.size();
        if (f) begin
            mq.delete();
            if (c) begin
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end
        end else begin
            rd_ok = r && (n > 0);
            wr_ok = w && ((n < DEPTH) || rd_ok);
            if (w && !wr_ok) m_ovf = 1'b1;
            else if (c)      m_ovf = 1'b0;
            if (r && n == 0) m_udf = 1'b1;
            else if (c)      m_udf = 1'b0;
            if (rd_ok) m_rdata = mq.pop_front();
            if (wr_ok) mq.push_back(d);
        end
        set_inputs(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_inputs(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (st0 !== RST_ST) $display("[TB] FAIL reset_status0 got=%h exp=%h", st0, RST_ST); else n_pass++;
        n_total++; if (st1 !== RST_ST) $display("[TB] FAIL reset_status1 got=%h exp=%h", st1, RST_ST); else n_pass++;
        n_total++; if (if0.rdata !== 32'h0) $display("[TB] FAIL reset_rdata0 got=%h exp=0", if0.rdata); else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h100 + i);
            n_total++; if (st0 !== exp_st()) $display("[TB] FAIL fill_status0 i=%0d got=%h exp=%h", i, st0, exp_st()); else n_pass++;
            n_total++; if (if0.walmost_full !== (i >= 13)) $display("[TB] FAIL fill_afull i=%0d got=%b exp=%b", i, if0.walmost_full, i >= 13); else n_pass++;
        end
        n_total++; if ({if0.count, if0.wfull} !== {5'd16, 1'b1}) $display("[TB] FAIL fill_full got=%0d/%b exp=16/1", if0.count, if0.wfull); else n_pass++;
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'hBAD);
        n_total++; if (if0.overflow !== 1'b1) $display("[TB] FAIL fill_overflow got=%b exp=1", if0.overflow); else n_pass++;
        n_total++; if (st1 !== exp_st()) $display("[TB] FAIL fill_status1 got=%h exp=%h", st1, exp_st()); else n_pass++;
    endtask

    task automatic test_drain();
        for (int i = 0; i < DEPTH; i++) begin
            n_total++; if (if1.rdata !== 32'h100 + i) $display("[TB] FAIL drain_fwft_head i=%0d got=%h exp=%h", i, if1.rdata, 32'h100 + i); else n_pass++;
            drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
            n_total++; if (if0.rdata !== 32'h100 + i) $display("[TB] FAIL drain_rdata i=%0d got=%h exp=%h", i, if0.rdata, 32'h100 + i); else n_pass++;
            n_total++; if (st0 !== exp_st()) $display("[TB] FAIL drain_status0 i=%0d got=%h exp=%h", i, st0, exp_st()); else n_pass++;
        end
        n_total++; if (if0.rempty !== 1'b1) $display("[TB] FAIL drain_empty got=%b exp=1", if0.rempty); else n_pass++;
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        n_total++; if (if0.underflow !== 1'b1) $display("[TB] FAIL drain_underflow got=%b exp=1", if0.underflow); else n_pass++;
        n_total++; if (if0.rdata !== 32'h10F) $display("[TB] FAIL drain_rdata_hold got=%h exp=10f", if0.rdata); else n_pass++;
    endtask

    task automatic test_clr_err();
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
        n_total++; if ({if0.overflow, if0.underflow} !== 2'b01) $display("[TB] FAIL clr_set_wins got=%b%b exp=01", if0.overflow, if0.underflow); else n_pass++;
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        n_total++; if ({if0.overflow, if0.underflow} !== 2'b00) $display("[TB] FAIL clr_err0 got=%b%b exp=00", if0.overflow, if0.underflow); else n_pass++;
        n_total++; if (st1 !== exp_st()) $display("[TB] FAIL clr_err1 got=%h exp=%h", st1, exp_st()); else n_pass++;
    endtask

    task automatic test_fwft();
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'hA5);
        n_total++; if (if1.rempty !== 1'b0) $display("[TB] FAIL fwft_rempty got=%b exp=0", if1.rempty); else n_pass++;
        n_total++; if (if1.rdata !== 32'hA5) $display("[TB] FAIL fwft_rdata got=%h exp=a5", if1.rdata); else n_pass++;
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        n_total++; if (if1.rempty !== 1'b1) $display("[TB] FAIL fwft_pop_empty got=%b exp=1", if1.rempty); else n_pass++;
        n_total++; if (if0.rdata !== 32'hA5) $display("[TB] FAIL fwft_reg_rdata got=%h exp=a5", if0.rdata); else n_pass++;
    endtask

    task automatic test_passthrough();
        logic [31:0] want;
        for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h200 + i);
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'hDEAD);
        n_total++; if ({if0.count, if0.overflow} !== {5'd16, 1'b0}) $display("[TB] FAIL pass_full got=%0d/%b exp=16/0", if0.count, if0.overflow); else n_pass++;
        n_total++; if (if0.rdata !== 32'h200) $display("[TB] FAIL pass_pop got=%h exp=200", if0.rdata); else n_pass++;
        for (int i = 0; i < DEPTH; i++) begin
            want = (i < DEPTH - 1) ? 32'h201 + i : 32'hDEAD;
            n_total++; if (if1.rdata !== want) $display("[TB] FAIL pass_fwft i=%0d got=%h exp=%h", i, if1.rdata, want); else n_pass++;
            drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
            n_total++; if (if0.rdata !== want) $display("[TB] FAIL pass_order i=%0d got=%h exp=%h", i, if0.rdata, want); else n_pass++;
        end
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h77);
        n_total++; if ({if0.count, if0.underflow} !== {5'd1, 1'b1}) $display("[TB] FAIL pass_empty got=%0d/%b exp=1/1", if0.count, if0.underflow); else n_pass++;
        n_total++; if (if1.rdata !== 32'h77) $display("[TB] FAIL pass_empty_data got=%h exp=77", if1.rdata); else n_pass++;
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
        n_total++; if (st0 !== exp_st()) $display("[TB] FAIL pass_clear got=%h exp=%h", st0, exp_st()); else n_pass++;
    endtask

    task automatic run_random(input string tag, input int cycles, input bit with_ctl);
        logic w, r, f, c;
        for (int i = 0; i < cycles; i++) begin
            w = ($urandom_range(7) != 0);
            r = ($urandom_range(7) != 0);
            f = with_ctl && ($urandom_range(31) == 0);
            c = with_ctl && ($urandom_range(15) == 0);
            drive_cycle(w, r, f, c, $urandom);
            n_total++; if (st0 !== exp_st()) $display("[TB] FAIL %s_status0 i=%0d got=%h exp=%h", tag, i, st0, exp_st()); else n_pass++;
            n_total++; if (st1 !== exp_st()) $display("[TB] FAIL %s_status1 i=%0d got=%h exp=%h", tag, i, st1, exp_st()); else n_pass++;
            n_total++; if (if0.rdata !== m_rdata) $display("[TB] FAIL %s_rdata0 i=%0d got=%h exp=%h", tag, i, if0.rdata, m_rdata); else n_pass++;
            if (mq.size() > 0) begin
                n_total++; if (if1.rdata !== head()) $display("[TB] FAIL %s_rdata1 i=%0d got=%h exp=%h", tag, i, if1.rdata, head()); else n_pass++;
            end
        end
    endtask

    task automatic test_flush();
        drive_cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
        for (int i = 0; i < 7; i++) drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h300 + i);
        n_total++; if (if0.count !== 5'd7) $display("[TB] FAIL flush_pre got=%0d exp=7", if0.count); else n_pass++;
        drive_cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h999);
        n_total++; if ({if0.count, if0.rempty} !== {5'd0, 1'b1}) $display("[TB] FAIL flush_empty got=%0d/%b exp=0/1", if0.count, if0.rempty); else n_pass++;
        n_total++; if ({if0.overflow, if0.underflow} !== 2'b00) $display("[TB] FAIL flush_err got=%b%b exp=00", if0.overflow, if0.underflow); else n_pass++;
        n_total++; if (if0.rdata !== m_rdata) $display("[TB] FAIL flush_rdata got=%h exp=%h", if0.rdata, m_rdata); else n_pass++;
        n_total++; if (st1 !== exp_st()) $display("[TB] FAIL flush_status1 got=%h exp=%h", st1, exp_st()); else n_pass++;
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h4242);
        n_total++; if (if1.rdata !== 32'h4242) $display("[TB] FAIL flush_refill got=%h exp=4242", if1.rdata); else n_pass++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, i[0], 1'b0, 1'b0, 32'h500 + i);
        set_inputs(1'b1, 1'b1, 1'b0, 1'b0, 32'h600);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_total++; if (st0 !== RST_ST) $display("[TB] FAIL rstmid_status0 got=%h exp=%h", st0, RST_ST); else n_pass++;
        n_total++; if (st1 !== RST_ST) $display("[TB] FAIL rstmid_status1 got=%h exp=%h", st1, RST_ST); else n_pass++;
        n_total++; if (if0.rdata !== 32'h0) $display("[TB] FAIL rstmid_rdata0 got=%h exp=0", if0.rdata); else n_pass++;
        set_inputs(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h55);
        n_total++; if (st0 !== exp_st()) $display("[TB] FAIL rstmid_after got=%h exp=%h", st0, exp_st()); else n_pass++;
        n_total++; if (if1.rdata !== 32'h55) $display("[TB] FAIL rstmid_fwft got=%h exp=55", if1.rdata); else n_pass++;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        test_reset();
        test_fill();
        test_drain();
        test_clr_err();
        test_fwft();
        test_passthrough();
        run_random("wrap", 40, 1'b0);
        test_flush();
        run_random("soak", 300, 1'b1);
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_total);
        $fatal(1, "[TB] watchdog");
    end
endmodule
